// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM encoding and default timing.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DELAY = 2'd1,
    REPEAT     = 2'd2
  } key_state_e;

  // Defaults assume a 50 MHz system clock.
  localparam int DEF_DB_CYCLES  = 500000;
  localparam int DEF_RPT_DELAY  = 25000000;
  localparam int DEF_RPT_PERIOD = 5000000;
  localparam int DEF_TIMER_W    = 25;

endpackage

// File: rtl/key_pulse_gen_if.sv
// Key conditioner signal bundle: raw key and repeat control in, strobe and status out.
interface key_pulse_gen_if;

  logic key_n;
  logic repeat_en;
  logic pulse;
  logic held;
  logic repeating;

  modport master (output key_n, repeat_en, input pulse, held, repeating);
  modport slave  (input key_n, repeat_en, output pulse, held, repeating);

endinterface

// File: rtl/key_debouncer.sv
// 2-FF synchroniser plus stable-level debounce timer producing the debounced press level.
module key_debouncer
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int TIMER_W   = DEF_TIMER_W
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n_i,
  output logic held_o,
  output logic held_nxt_o
);

  localparam logic [TIMER_W-1:0] DB_LAST = TIMER_W'(DB_CYCLES - 1);

  logic               s1_q, s2_q;
  logic               held_q, held_d;
  logic [TIMER_W-1:0] tmr_q, tmr_d;
  logic               ks;

  assign ks = ~s2_q;

  // Timer counts consecutive cycles that disagree with the accepted level.
  always_comb begin
    held_d = held_q;
    tmr_d  = '0;
    if (ks != held_q) begin
      if (tmr_q == DB_LAST) held_d = ks;
      else                  tmr_d  = tmr_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      held_q <= 1'b0;
      tmr_q  <= '0;
    end else begin
      s1_q   <= key_n_i;
      s2_q   <= s1_q;
      held_q <= held_d;
      tmr_q  <= tmr_d;
    end
  end

  assign held_o     = held_q;
  assign held_nxt_o = held_d;

endmodule

// File: rtl/key_pulse_gen.sv
// Pushbutton conditioner: debounced press strobe with optional auto-repeat while held.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter int TIMER_W    = DEF_TIMER_W
) (
  input  logic            Clock,
  input  logic            Resetn,
  key_pulse_gen_if.slave  bus
);

  localparam logic [TIMER_W-1:0] DLY_LAST = TIMER_W'(RPT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PER_LAST = TIMER_W'(RPT_PERIOD - 1);

  logic               held, held_nxt;
  key_state_e         state_q;
  logic [TIMER_W-1:0] tmr_q;
  logic               pulse_q, rep_q;

  key_debouncer #(
    .DB_CYCLES (DB_CYCLES),
    .TIMER_W   (TIMER_W)
  ) u_db (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .key_n_i    (bus.key_n),
    .held_o     (held),
    .held_nxt_o (held_nxt)
  );

  // FSM looks at the next debounced level so a release on the same edge as a
  // repeat expiry suppresses that pulse.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      pulse_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (held_nxt && !held) begin
            pulse_q <= 1'b1;
            tmr_q   <= '0;
            state_q <= WAIT_DELAY;
          end
        end
        WAIT_DELAY: begin
          if (!held_nxt) begin
            state_q <= IDLE;
          end else if (!bus.repeat_en) begin
            tmr_q <= '0;
          end else if (tmr_q == DLY_LAST) begin
            pulse_q <= 1'b1;
            tmr_q   <= '0;
            state_q <= REPEAT;
            rep_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TIMER_W'(1);
          end
        end
        REPEAT: begin
          if (!held_nxt) begin
            state_q <= IDLE;
            rep_q   <= 1'b0;
          end else if (!bus.repeat_en) begin
            tmr_q   <= '0;
            state_q <= WAIT_DELAY;
            rep_q   <= 1'b0;
          end else if (tmr_q == PER_LAST) begin
            pulse_q <= 1'b1;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TIMER_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          rep_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse     = pulse_q;
  assign bus.held      = held;
  assign bus.repeating = rep_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed and randomized checks of key_pulse_gen against a cycle-level behavioural model.
module tb_key_pulse_gen;

  localparam int DB  = 4;
  localparam int DLY = 8;
  localparam int PER = 3;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_REP = 2;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  key_pulse_gen_if bus ();

  key_pulse_gen #(
    .DB_CYCLES  (DB),
    .RPT_DELAY  (DLY),
    .RPT_PERIOD (PER),
    .TIMER_W    (8)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  int   total = 0, bad = 0, npulse = 0;
  logic prev_pulse = 1'b0;

  // reference model state: last two key samples, accepted level, phase counters
  logic [1:0] kh;
  logic       m_held, m_pulse, m_rep;
  int         m_run, m_cnt, m_ph;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_rst();
    kh = 2'b11; m_held = 1'b0; m_pulse = 1'b0; m_rep = 1'b0;
    m_run = 0; m_cnt = 0; m_ph = PH_IDLE;
  endtask

  task automatic model_step();
    logic ks, rise;
    if (!Resetn) begin
      model_rst();
      return;
    end
    ks   = ~kh[1];
    rise = 1'b0;
    if (ks != m_held) begin
      m_run++;
      if (m_run == DB) begin
        m_held = ks; m_run = 0; rise = ks;
      end
    end else m_run = 0;
    m_pulse = 1'b0;
    if (rise) begin
      m_pulse = 1'b1; m_ph = PH_WAIT; m_cnt = 0;
    end else if (!m_held) begin
      m_ph = PH_IDLE;
    end else if (m_ph == PH_WAIT) begin
      if (!bus.repeat_en) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == DLY) begin m_pulse = 1'b1; m_ph = PH_REP; m_cnt = 0; end
      end
    end else if (m_ph == PH_REP) begin
      if (!bus.repeat_en) begin m_ph = PH_WAIT; m_cnt = 0; end
      else begin
        m_cnt++;
        if (m_cnt == PER) begin m_pulse = 1'b1; m_cnt = 0; end
      end
    end
    m_rep = (m_ph == PH_REP);
    kh = {kh[0], bus.key_n};
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    chk("pulse", int'(bus.pulse), int'(m_pulse));
    chk("held", int'(bus.held), int'(m_held));
    chk("repeating", int'(bus.repeating), int'(m_rep));
    chk("no_back2back", int'(bus.pulse & prev_pulse), 0);
    prev_pulse = bus.pulse;
    if (bus.pulse) npulse++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pulse(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (bus.pulse) begin n = i; break; end
    end
  endtask

  task automatic do_reset();
    #2;
    Resetn = 1'b0;
    #1;
    chk("rst_pulse", int'(bus.pulse), 0);
    chk("rst_held", int'(bus.held), 0);
    chk("rst_repeating", int'(bus.repeating), 0);
    model_rst();
    prev_pulse = 1'b0;
    ticks(2);
    Resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, cnt;
    logic lvl, seen;
    model_rst();
    bus.key_n = 1'b1;
    bus.repeat_en = 1'b0;
    ticks(3);
    Resetn = 1'b1;
    ticks(3);

    // reset mid-REPEAT with key held, then one pulse after debounce latency
    bus.key_n = 1'b0; bus.repeat_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.repeating) break;
    end
    chk("reach_repeat", int'(bus.repeating), 1);
    bus.repeat_en = 1'b0;
    do_reset();
    n0 = npulse;
    wait_pulse(12, n);
    chk("rst_press_lat", n, 6);
    ticks(15);
    chk("rst_one_pulse", npulse - n0, 1);
    bus.key_n = 1'b1;
    ticks(10);

    // bounce shorter than debounce window
    n0 = npulse; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.key_n = ((i / 2) % 2) == 0;
      tick();
      seen |= bus.held;
    end
    bus.key_n = 1'b1;
    ticks(10);
    chk("bounce_pulses", npulse - n0, 0);
    chk("bounce_held", int'(seen), 0);

    // clean press without repeat
    n0 = npulse;
    bus.key_n = 1'b0;
    ticks(40);
    chk("press_pulses", npulse - n0, 1);
    chk("press_held", int'(bus.held), 1);
    bus.key_n = 1'b1;
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (!bus.held) begin n = i; break; end
    end
    chk("release_lat", n, 6);
    ticks(5);

    // auto-repeat timing, then release colliding with a repeat expiry
    bus.repeat_en = 1'b1;
    bus.key_n = 1'b0;
    wait_pulse(10, n);
    chk("rpt_first", n, 6);
    wait_pulse(20, n);
    chk("rpt_delay", n, DLY);
    chk("rpt_repeating", int'(bus.repeating), 1);
    wait_pulse(20, n);
    chk("rpt_period1", n, PER);
    wait_pulse(20, n);
    chk("rpt_period2", n, PER);
    bus.key_n = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.pulse) cnt++;
      if (i == 6) begin
        chk("collide_pulse", int'(bus.pulse), 0);
        chk("collide_held", int'(bus.held), 0);
        chk("collide_rep", int'(bus.repeating), 0);
      end
    end
    chk("collide_cnt", cnt, 1);

    // repeat_en dropped in REPEAT then re-raised: full delay restarts
    bus.key_n = 1'b0;
    wait_pulse(10, n);
    chk("re_first", n, 6);
    wait_pulse(20, n);
    chk("re_delay", n, DLY);
    bus.repeat_en = 1'b0;
    n0 = npulse;
    ticks(5);
    chk("re_quiet", npulse - n0, 0);
    bus.repeat_en = 1'b1;
    wait_pulse(20, n);
    chk("re_restart", n, DLY);
    bus.key_n = 1'b1;
    ticks(10);

    // randomized segments with bounce, repeat_en flips and occasional reset
    for (int s = 0; s < 150; s++) begin
      lvl = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
        bus.key_n = lvl ^ ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) bus.repeat_en = ~bus.repeat_en;
        tick();
      end
      if ($urandom_range(0, 29) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
